// File: rtl/bcd_binary_converter.sv
// rtl/bcd_binary_converter.sv - sequential reverse double-dabble BCD-to-binary converter
// Optional invalid-digit check is enabled by defining BCD_BIN_CHECK_EN.
module bcd_binary_converter #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [4*DIGITS-1:0] bcd,
   output logic [BIN_W-1:0]    bin,
   output logic                busy,
   output logic                done,
   output logic                err
);
   localparam int SR_W  = 4*DIGITS + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

   state_t           r_state;
   logic [SR_W-1:0]  r_sr;
   logic [CNT_W-1:0] r_cnt;
   logic [SR_W-1:0]  w_shift;
   logic [SR_W-1:0]  w_sr_next;

   // One reverse double-dabble step: shift right, then pull every digit >= 8 back by 3.
   always_comb begin
      w_shift   = r_sr >> 1;
      w_sr_next = w_shift;
      for (int d = 0; d < DIGITS; d++) begin
         if (w_shift[BIN_W+4*d +: 4] >= 4'd8)
            w_sr_next[BIN_W+4*d +: 4] = w_shift[BIN_W+4*d +: 4] - 4'd3;
      end
   end

`ifdef BCD_BIN_CHECK_EN
   logic w_bad;
   logic r_bad;

   always_comb begin
      w_bad = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd[4*d +: 4] > 4'd9)
            w_bad = 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_sr    <= '0;
         r_cnt   <= '0;
         bin     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef BCD_BIN_CHECK_EN
         r_bad   <= 1'b0;
         err     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               busy <= 1'b0;
               if (start) begin
                  busy  <= 1'b1;
                  r_cnt <= '0;
                  r_sr  <= {bcd, {BIN_W{1'b0}}};
`ifdef BCD_BIN_CHECK_EN
                  r_bad <= w_bad;
                  if (w_bad) begin
                     // Bad digits bypass the shifter so the result reads as zero.
                     r_sr    <= '0;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_CONV;
                  end
`else
                  r_state <= S_CONV;
`endif
               end
            end
            S_CONV: begin
               r_sr  <= w_sr_next;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(BIN_W - 1))
                  r_state <= S_DONE;
            end
            S_DONE: begin
               bin     <= r_sr[BIN_W-1:0];
               done    <= 1'b1;
               busy    <= 1'b1;
`ifdef BCD_BIN_CHECK_EN
               err     <= r_bad;
`endif
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_binary_converter.sv
// tb/tb_bcd_binary_converter.sv - randomized self-checking bench for bcd_binary_converter
module tb_bcd_binary_converter;
   localparam int DIGITS = 3;
   localparam int BIN_W  = 10;
   localparam int LAT    = BIN_W + 2;

   logic              clk;
   logic              rst;
   logic              start;
   logic [11:0]       bcd;
   logic [BIN_W-1:0]  bin;
   logic              busy;
   logic              done;
   logic              err;

   int n_checks = 0;
   int n_pass   = 0;

   bcd_binary_converter #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bcd   (bcd),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int bcd_value(input logic [11:0] b);
      int v = 0;
      int w = 1;
      for (int i = 0; i < DIGITS; i++) begin
         v = v + int'(b[4*i +: 4]) * w;
         w = w * 10;
      end
      return v;
   endfunction

   function automatic logic [11:0] to_bcd(input int v);
      logic [11:0] b;
      b[3:0]  = 4'(v % 10);
      b[7:4]  = 4'((v / 10) % 10);
      b[11:8] = 4'((v / 100) % 10);
      return b;
   endfunction

   // Issues one conversion from an idle DUT; lat counts cycles from accept to the done cycle.
   task automatic convert(input logic [11:0] b, output logic [BIN_W-1:0] res,
                          output logic e, output int lat, output int busy_n);
      lat    = -1;
      busy_n = 0;
      res    = 'x;
      e      = 1'bx;
      bcd    = b;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      bcd    = 12'($urandom);
      for (int c = 1; c <= 40; c++) begin
         if (busy) busy_n++;
         if (done) begin
            lat = c;
            res = bin;
            e   = err;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; bcd = 12'h000;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({bin, busy, done, err} !== {{BIN_W{1'b0}}, 3'b000})
         $display("FAIL reset_outputs: got bin=%0d busy=%b done=%b err=%b, want all zero",
                  bin, busy, done, err);
      else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_zero();
      logic [BIN_W-1:0] r; logic e; int lat, bn;
      convert(12'h000, r, e, lat, bn);
      n_checks++;
      if (lat !== LAT) $display("FAIL zero_latency: got %0d want %0d", lat, LAT);
      else n_pass++;
      n_checks++;
      if (r !== 10'd0 || e !== 1'b0) $display("FAIL zero_result: got bin=%0d err=%b want 0/0", r, e);
      else n_pass++;
   endtask

   task automatic test_max();
      logic [BIN_W-1:0] r; logic e; int lat, bn;
      convert(12'h999, r, e, lat, bn);
      n_checks++;
      if (r !== 10'd999) $display("FAIL max_result: got %0d want 999", r);
      else n_pass++;
      n_checks++;
      if (bn !== LAT) $display("FAIL max_busy_cycles: got %0d want %0d", bn, LAT);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0)
         $display("FAIL max_after_done: got done=%b busy=%b want 0/0", done, busy);
      else n_pass++;
   endtask

   task automatic test_sweep();
      int order[1000];
      int j, tmp, lat, bn, bad_res, bad_lat, bad_err;
      logic [BIN_W-1:0] r; logic e;
      for (int i = 0; i < 1000; i++) order[i] = i;
      for (int i = 999; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      bad_res = 0; bad_lat = 0; bad_err = 0;
      for (int i = 0; i < 1000; i++) begin
         convert(to_bcd(order[i]), r, e, lat, bn);
         n_checks++;
         if (r !== BIN_W'(order[i])) begin
            if (bad_res < 5) $display("FAIL sweep_result: bcd=%h got %0d want %0d",
                                      to_bcd(order[i]), r, order[i]);
            bad_res++;
         end else n_pass++;
         n_checks++;
         if (lat !== LAT || e !== 1'b0) begin
            if (bad_lat < 5) $display("FAIL sweep_timing: bcd=%h got lat=%0d err=%b want %0d/0",
                                      to_bcd(order[i]), lat, e, LAT);
            bad_lat++;
         end else n_pass++;
      end
   endtask

   task automatic test_ignore_start();
      logic [BIN_W-1:0] r, r2; logic e; int lat, bn, t_done, n_done;
      t_done = -1; n_done = 0; r = 'x;
      bcd = 12'h255; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         if (c == 4) begin start = 1'b1; bcd = 12'h001; end
         else if (c == 5) begin start = 1'b0; bcd = 12'h000; end
         if (done) begin
            n_done++;
            if (t_done < 0) begin t_done = c; r = bin; end
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (t_done !== LAT || r !== 10'd255)
         $display("FAIL ignore_first: got t=%0d bin=%0d want %0d/255", t_done, r, LAT);
      else n_pass++;
      n_checks++;
      if (n_done !== 1) $display("FAIL ignore_no_queue: got %0d done pulses want 1", n_done);
      else n_pass++;
      convert(12'h001, r2, e, lat, bn);
      n_checks++;
      if (r2 !== 10'd1) $display("FAIL ignore_next: got %0d want 1", r2);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int t1, t2;
      logic [BIN_W-1:0] r1, r2;
      t1 = -1; t2 = -1; r1 = 'x; r2 = 'x;
      bcd = 12'h314; start = 1'b1;
      @(posedge clk); #1;
      bcd = 12'h862;
      for (int c = 1; c <= 40 && t2 < 0; c++) begin
         if (t1 > 0 && c == t1 + 1) start = 1'b0;
         if (done) begin
            if (t1 < 0) begin t1 = c; r1 = bin; end
            else begin t2 = c; r2 = bin; end
         end
         if (t2 < 0) begin @(posedge clk); #1; end
      end
      start = 1'b0;
      n_checks++;
      if (t1 !== LAT || t2 !== 2*LAT)
         $display("FAIL b2b_timing: got %0d,%0d want %0d,%0d", t1, t2, LAT, 2*LAT);
      else n_pass++;
      n_checks++;
      if (r1 !== 10'd314 || r2 !== 10'd862)
         $display("FAIL b2b_results: got %0d,%0d want 314,862", r1, r2);
      else n_pass++;
   endtask

   task automatic test_abort();
      logic [BIN_W-1:0] r; logic e; int lat, bn, n_done;
      n_done = 0;
      bcd = 12'h777; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < 5; c++) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || bin !== 10'd0)
         $display("FAIL abort_state: got busy=%b done=%b bin=%0d want 0/0/0", busy, done, bin);
      else n_pass++;
      for (int c = 0; c < 20; c++) begin
         if (done) n_done++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (n_done !== 0) $display("FAIL abort_no_done: got %0d done pulses want 0", n_done);
      else n_pass++;
      convert(12'h042, r, e, lat, bn);
      n_checks++;
      if (r !== 10'd42 || lat !== LAT)
         $display("FAIL abort_recover: got bin=%0d lat=%0d want 42/%0d", r, lat, LAT);
      else n_pass++;
   endtask

   task automatic test_invalid();
      logic [BIN_W-1:0] r; logic e; int lat, bn;
      logic [11:0] b;
      int k;
      for (int i = 0; i < 12; i++) begin
         if (i == 0) b = 12'h1A3;
         else begin
            b = to_bcd(int'($urandom_range(999, 0)));
            k = int'($urandom_range(DIGITS - 1, 0));
            b[4*k +: 4] = 4'(10 + $urandom_range(5, 0));
         end
         convert(b, r, e, lat, bn);
`ifdef BCD_BIN_CHECK_EN
         n_checks++;
         if (lat !== 2 || e !== 1'b1 || r !== 10'd0)
            $display("FAIL invalid_checked: bcd=%h got lat=%0d err=%b bin=%0d want 2/1/0",
                     b, lat, e, r);
         else n_pass++;
`else
         n_checks++;
         if (lat !== LAT || e !== 1'b0)
            $display("FAIL invalid_unchecked: bcd=%h got lat=%0d err=%b want %0d/0",
                     b, lat, e, LAT);
         else n_pass++;
`endif
      end
      convert(12'h506, r, e, lat, bn);
      n_checks++;
      if (r !== BIN_W'(bcd_value(12'h506)) || e !== 1'b0)
         $display("FAIL invalid_then_valid: got bin=%0d err=%b want 506/0", r, e);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_zero();
      test_max();
      test_sweep();
      test_ignore_start();
      test_back_to_back();
      test_abort();
      test_invalid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
